stab_register_array_v2: RTL and testbench

//  Parametrised stabilizer-matrix store: NUM_QUBIT rows x NUM_QUBIT literal columns plus MAX_VECTOR phase bits per row.

---
 rtl/stab_register_array_v2_pkg.sv | 31 +++
 rtl/stab_register_array_v2_gate_info_fifo.sv | 64 ++++++
 rtl/stab_register_array_v2.sv | 237 +++++++++++++++++++++++
 tb/tb_stab_register_array_v2.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stab_register_array_v2_pkg.sv
// Shared types for the stabilizer register array: command opcodes, seek FSM
// states and the gate-info record carried by the gate FIFO.
package stab_reg_pkg;

  localparam int GI_POS_W = 32;

  typedef enum logic [2:0] {
    NOP       = 3'd0,
    SHIFT_IN  = 3'd1,
    ROT_DOWN  = 3'd2,
    ROT_LEFT  = 3'd3,
    ROT_RIGHT = 3'd4,
    SEEK_COL  = 3'd5,
    CLEAR     = 3'd6,
    WRITEBACK = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEEK = 1'b1
  } seek_state_e;

  typedef logic [1:0] gate_type_t;

  typedef struct packed {
    gate_type_t            gate_type;
    logic [GI_POS_W-1:0]   pos;
    logic [GI_POS_W-1:0]   pos2;
  } gate_info_t;

endpackage

// File: rtl/stab_register_array_v2_gate_info_fifo.sv
// First-word-fall-through FIFO of gate_info_t records; the head is visible
// combinationally and reads as zero while the FIFO is empty.
module gate_info_fifo
  import stab_reg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_new,
  input  logic                      push,
  input  logic                      pop,
  input  gate_info_t                din,
  output gate_info_t                dout,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);

  gate_info_t       mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

  // A pop frees the slot this same edge, so a push against a full FIFO may proceed.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  assign dout = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst_new) begin
    if (rst_new) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/stab_register_array_v2.sv
// Stabilizer-matrix store with command handshake, row/column rotation, SEEK_COL
// FSM, column-offset tracking, P register and gate-info FIFO.
// Optional feature macro: REG_ARRAY_WRITEBACK_EN (adds wb ports and op 7 WRITEBACK).
module stab_register_array_v2
  import stab_reg_pkg::*;
#(
  parameter int NUM_QUBIT  = 4,
  parameter int MAX_VECTOR = 2**NUM_QUBIT,
  parameter int POS_W      = 32,
  parameter int GI_DEPTH   = 4,
  parameter int CW         = (NUM_QUBIT > 1) ? $clog2(NUM_QUBIT) : 1
) (
  input  logic                                clk,
  input  logic                                rst_new,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [2:0]                          cmd_op,
  input  logic [CW-1:0]                       cmd_col,
  input  logic [2*NUM_QUBIT-1:0]              literals_in,
  input  logic [MAX_VECTOR-1:0]               phase_in,
  output logic [2*NUM_QUBIT-1:0]              literals_out,
  output logic [MAX_VECTOR-1:0]               phase_out,
  output logic [CW-1:0]                       col_offset,
  output logic                                busy,
  output logic                                seek_done,
  input  logic                                gi_push,
  input  logic                                gi_pop,
  input  logic [1:0]                          gi_gate_type,
  input  logic [POS_W-1:0]                    gi_pos,
  input  logic [POS_W-1:0]                    gi_pos2,
  output logic [1:0]                          go_gate_type,
  output logic [POS_W-1:0]                    go_pos,
  output logic [POS_W-1:0]                    go_pos2,
  output logic                                gi_full,
  output logic                                gi_empty,
  output logic [$clog2(GI_DEPTH):0]           gi_count,
  input  logic [2*NUM_QUBIT*MAX_VECTOR-1:0]   literals_P,
  input  logic                                phase_P,
  input  logic                                valid_P,
  output logic [2*NUM_QUBIT*MAX_VECTOR-1:0]   reg_literals_P,
  output logic                                reg_phase_P
`ifdef REG_ARRAY_WRITEBACK_EN
  ,
  input  logic [2*NUM_QUBIT-1:0]              wb_literals,
  input  logic [MAX_VECTOR-1:0]               wb_phase
`endif
);

  localparam int LW  = 2*NUM_QUBIT;
  localparam int PLW = 2*NUM_QUBIT*MAX_VECTOR;

  logic [LW-1:0]          lit_reg  [NUM_QUBIT];
  logic [LW-1:0]          lit_next [NUM_QUBIT];
  logic [MAX_VECTOR-1:0]  ph_reg   [NUM_QUBIT];
  logic [MAX_VECTOR-1:0]  ph_next  [NUM_QUBIT];
  logic [CW-1:0]          col_offset_reg, col_offset_next;
  logic [CW-1:0]          target_reg, target_next;
  logic [CW-1:0]          col_inc, col_dec;
  seek_state_e            state_reg, state_next;
  logic                   seek_done_reg, seek_done_next;
  logic                   seek_step;
  logic [PLW-1:0]         p_lit_reg;
  logic                   p_ph_reg;
  op_e                    op;
  logic                   fire;
  logic                   do_shift, do_rotd, do_rotl, do_rotr, do_clear, do_wb;
  logic [LW-1:0]          wb_lit;
  logic [MAX_VECTOR-1:0]  wb_ph;

  // Column j of a row occupies literal bits [2j+1:2j].
  function automatic logic [LW-1:0] rot_l(input logic [LW-1:0] row);
    rot_l = row;
    for (int j = 0; j < NUM_QUBIT; j++) begin
      rot_l[2*j +: 2] = row[2*((j + 1) % NUM_QUBIT) +: 2];
    end
  endfunction

  function automatic logic [LW-1:0] rot_r(input logic [LW-1:0] row);
    rot_r = row;
    for (int j = 0; j < NUM_QUBIT; j++) begin
      rot_r[2*j +: 2] = row[2*((j + NUM_QUBIT - 1) % NUM_QUBIT) +: 2];
    end
  endfunction

  assign op        = op_e'(cmd_op);
  assign cmd_ready = (state_reg == ST_IDLE);
  assign busy      = (state_reg == ST_SEEK);
  assign fire      = cmd_valid && cmd_ready;

  assign do_shift = fire && (op == SHIFT_IN);
  assign do_rotd  = fire && (op == ROT_DOWN);
  assign do_rotl  = (fire && (op == ROT_LEFT)) || seek_step;
  assign do_rotr  = fire && (op == ROT_RIGHT);
  assign do_clear = fire && (op == CLEAR);

`ifdef REG_ARRAY_WRITEBACK_EN
  assign do_wb  = fire && (op == WRITEBACK);
  assign wb_lit = wb_literals;
  assign wb_ph  = wb_phase;
`else
  assign do_wb  = 1'b0;
  assign wb_lit = '0;
  assign wb_ph  = '0;
`endif

  assign col_inc = (col_offset_reg == CW'(NUM_QUBIT-1)) ? '0 : col_offset_reg + CW'(1);
  assign col_dec = (col_offset_reg == '0) ? CW'(NUM_QUBIT-1) : col_offset_reg - CW'(1);

  for (genvar gi = 0; gi < NUM_QUBIT; gi++) begin : g_row
    logic [LW-1:0]         lit_above;
    logic [MAX_VECTOR-1:0] ph_above;
    logic                  row_wb;

    // Row 0 receives either the new input row or the wrapped-around last row.
    if (gi == 0) begin : g_first
      assign lit_above = do_shift ? literals_in : lit_reg[NUM_QUBIT-1];
      assign ph_above  = do_shift ? phase_in    : ph_reg[NUM_QUBIT-1];
    end else begin : g_rest
      assign lit_above = lit_reg[gi-1];
      assign ph_above  = ph_reg[gi-1];
    end

    assign row_wb = do_wb && (gi == NUM_QUBIT-1);

    assign lit_next[gi] = do_clear             ? '0 :
                          (do_shift || do_rotd) ? lit_above :
                          do_rotl              ? rot_l(lit_reg[gi]) :
                          do_rotr              ? rot_r(lit_reg[gi]) :
                          row_wb               ? wb_lit :
                                                 lit_reg[gi];

    assign ph_next[gi]  = do_clear             ? '0 :
                          (do_shift || do_rotd) ? ph_above :
                          row_wb               ? wb_ph :
                                                 ph_reg[gi];
  end

  always_comb begin
    col_offset_next = col_offset_reg;
    if (do_clear) begin
      col_offset_next = '0;
    end else if (do_rotl) begin
      col_offset_next = col_inc;
    end else if (do_rotr) begin
      col_offset_next = col_dec;
    end
  end

  always_comb begin
    state_next     = state_reg;
    target_next    = target_reg;
    seek_done_next = 1'b0;
    seek_step      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (fire && (op == SEEK_COL)) begin
          if (cmd_col == col_offset_reg) begin
            seek_done_next = 1'b1;
          end else begin
            state_next  = ST_SEEK;
            target_next = cmd_col;
          end
        end
      end
      ST_SEEK: begin
        // Leave on the edge that performs the final rotation, so busy spans exactly the rotate cycles.
        seek_step = 1'b1;
        if (col_inc == target_reg) begin
          state_next     = ST_IDLE;
          seek_done_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_new) begin
    if (rst_new) begin
      for (int r = 0; r < NUM_QUBIT; r++) begin
        lit_reg[r] <= '0;
        ph_reg[r]  <= '0;
      end
      col_offset_reg <= '0;
      target_reg     <= '0;
      state_reg      <= ST_IDLE;
      seek_done_reg  <= 1'b0;
      p_lit_reg      <= '0;
      p_ph_reg       <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_QUBIT; r++) begin
        lit_reg[r] <= lit_next[r];
        ph_reg[r]  <= ph_next[r];
      end
      col_offset_reg <= col_offset_next;
      target_reg     <= target_next;
      state_reg      <= state_next;
      seek_done_reg  <= seek_done_next;
      if (valid_P) begin
        p_lit_reg <= literals_P;
        p_ph_reg  <= phase_P;
      end
    end
  end

  assign literals_out   = lit_reg[NUM_QUBIT-1];
  assign phase_out      = ph_reg[NUM_QUBIT-1];
  assign col_offset     = col_offset_reg;
  assign seek_done      = seek_done_reg;
  assign reg_literals_P = p_lit_reg;
  assign reg_phase_P    = p_ph_reg;

  gate_info_t gi_din;
  gate_info_t gi_dout;

  assign gi_din.gate_type = gi_gate_type;
  assign gi_din.pos       = gi_pos;
  assign gi_din.pos2      = gi_pos2;

  gate_info_fifo #(
    .DEPTH (GI_DEPTH)
  ) u_gate_info_fifo (
    .clk   (clk),
    .rst_new (rst_new),
    .push  (gi_push),
    .pop   (gi_pop),
    .din   (gi_din),
    .dout  (gi_dout),
    .full  (gi_full),
    .empty (gi_empty),
    .count (gi_count)
  );

  assign go_gate_type = gi_dout.gate_type;
  assign go_pos       = gi_dout.pos;
  assign go_pos2      = gi_dout.pos2;

endmodule

// File: tb/tb_stab_register_array_v2.sv
// Directed self-checking bench for stab_register_array_v2 (NUM_QUBIT=4, MAX_VECTOR=16).
// Honours REG_ARRAY_WRITEBACK_EN to exercise op 7 either as WRITEBACK or as NOP.
module tb_stab_register_array_v2;
  import stab_reg_pkg::*;

  localparam int N   = 4;
  localparam int MV  = 16;
  localparam int PW  = 32;
  localparam int GD  = 4;
  localparam int CW  = 2;
  localparam int LW  = 2*N;
  localparam int PLW = 2*N*MV;

  logic            clk = 1'b0;
  logic            rst_new;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_op;
  logic [CW-1:0]   cmd_col;
  logic [LW-1:0]   literals_in;
  logic [MV-1:0]   phase_in;
  logic [LW-1:0]   literals_out;
  logic [MV-1:0]   phase_out;
  logic [CW-1:0]   col_offset;
  logic            busy;
  logic            seek_done;
  logic            gi_push, gi_pop;
  logic [1:0]      gi_gate_type;
  logic [PW-1:0]   gi_pos, gi_pos2;
  logic [1:0]      go_gate_type;
  logic [PW-1:0]   go_pos, go_pos2;
  logic            gi_full, gi_empty;
  logic [2:0]      gi_count;
  logic [PLW-1:0]  literals_P;
  logic            phase_P, valid_P;
  logic [PLW-1:0]  reg_literals_P;
  logic            reg_phase_P;
`ifdef REG_ARRAY_WRITEBACK_EN
  logic [LW-1:0]   wb_literals;
  logic [MV-1:0]   wb_phase;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stab_register_array_v2 #(
    .NUM_QUBIT (N), .MAX_VECTOR (MV), .POS_W (PW), .GI_DEPTH (GD), .CW (CW)
  ) dut (
    .clk (clk), .rst_new (rst_new),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_op (cmd_op), .cmd_col (cmd_col),
    .literals_in (literals_in), .phase_in (phase_in),
    .literals_out (literals_out), .phase_out (phase_out),
    .col_offset (col_offset), .busy (busy), .seek_done (seek_done),
    .gi_push (gi_push), .gi_pop (gi_pop), .gi_gate_type (gi_gate_type),
    .gi_pos (gi_pos), .gi_pos2 (gi_pos2),
    .go_gate_type (go_gate_type), .go_pos (go_pos), .go_pos2 (go_pos2),
    .gi_full (gi_full), .gi_empty (gi_empty), .gi_count (gi_count),
    .literals_P (literals_P), .phase_P (phase_P), .valid_P (valid_P),
    .reg_literals_P (reg_literals_P), .reg_phase_P (reg_phase_P)
`ifdef REG_ARRAY_WRITEBACK_EN
    , .wb_literals (wb_literals), .wb_phase (wb_phase)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one command for a single clock edge; returns at the following negedge.
  task automatic cmd(input op_e op, input logic [CW-1:0] col, input logic [LW-1:0] lit,
                     input logic [MV-1:0] ph);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_col     = col;
    literals_in = lit;
    phase_in    = ph;
    @(negedge clk);
    cmd_valid = 1'b0;
    $display("cmd %s col=%0d lit_in=%h -> lit_out=%h ph_out=%h col_offset=%0d",
             op.name(), col, lit, literals_out, phase_out, col_offset);
  endtask

  task automatic fifo(input logic push, input logic pop, input logic [1:0] t,
                      input logic [PW-1:0] p, input logic [PW-1:0] p2);
    gi_push = push; gi_pop = pop; gi_gate_type = t; gi_pos = p; gi_pos2 = p2;
    @(negedge clk);
    gi_push = 1'b0; gi_pop = 1'b0;
    $display("fifo push=%0b pop=%0b -> count=%0d head_pos=%0d full=%0b empty=%0b",
             push, pop, gi_count, go_pos, gi_full, gi_empty);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, done_cnt, ready_bad, done_at;

    rst_new = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_col = '0; literals_in = '0; phase_in = '0;
    gi_push = 1'b0; gi_pop = 1'b0; gi_gate_type = '0; gi_pos = '0; gi_pos2 = '0;
    literals_P = '0; phase_P = 1'b0; valid_P = 1'b0;
`ifdef REG_ARRAY_WRITEBACK_EN
    wb_literals = '0; wb_phase = '0;
`endif
    repeat (3) @(negedge clk);
    rst_new = 1'b0;

    // Reset state
    chk("rst_lit_out", literals_out, 0);
    chk("rst_phase_out", phase_out, 0);
    chk("rst_col_offset", col_offset, 0);
    chk("rst_busy", busy, 0);
    chk("rst_seek_done", seek_done, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_gi_count", gi_count, 0);
    chk("rst_gi_empty", gi_empty, 1);
    chk("rst_go_pos", go_pos, 0);
    chk("rst_reg_lit_P", reg_literals_P, 0);

    // SHIFT_IN rows A..D; row 3 holds the oldest (A)
    cmd(SHIFT_IN, 0, 8'h1B, 16'hA001);
    chk("shift1_lit_out", literals_out, 0);
    cmd(SHIFT_IN, 0, 8'h2C, 16'hB002);
    cmd(SHIFT_IN, 0, 8'h3D, 16'hC003);
    cmd(SHIFT_IN, 0, 8'h4E, 16'hD004);
    chk("shift4_lit_out", literals_out, 8'h1B);
    chk("shift4_ph_out", phase_out, 16'hA001);

    // ROT_DOWN: row0<=row3, row i<=row i-1, so row 3 walks B, C, D, A
    cmd(ROT_DOWN, 0, 0, 0);
    chk("rotd1_lit_out", literals_out, 8'h2C);
    chk("rotd1_ph_out", phase_out, 16'hB002);
    cmd(ROT_DOWN, 0, 0, 0);
    cmd(ROT_DOWN, 0, 0, 0);
    chk("rotd3_lit_out", literals_out, 8'h4E);
    cmd(ROT_DOWN, 0, 0, 0);
    chk("rotd4_lit_out", literals_out, 8'h1B);
    chk("rotd_col_offset", col_offset, 0);

    // Column rotation on a row with columns {0,1,2,3} = 8'hE4
    cmd(CLEAR, 0, 0, 0);
    chk("clear_lit_out", literals_out, 0);
    cmd(SHIFT_IN, 0, 8'hE4, 16'h5555);
    cmd(SHIFT_IN, 0, 0, 0);
    cmd(SHIFT_IN, 0, 0, 0);
    cmd(SHIFT_IN, 0, 0, 0);
    chk("row_e4_lit_out", literals_out, 8'hE4);
    cmd(ROT_LEFT, 0, 0, 0);
    chk("rotl_lit_out", literals_out, 8'h39);
    chk("rotl_col_offset", col_offset, 1);
    chk("rotl_ph_held", phase_out, 16'h5555);
    cmd(ROT_RIGHT, 0, 0, 0);
    chk("rotr1_lit_out", literals_out, 8'hE4);
    chk("rotr1_col_offset", col_offset, 0);
    cmd(ROT_RIGHT, 0, 0, 0);
    chk("rotr2_lit_out", literals_out, 8'h93);
    chk("rotr2_col_offset", col_offset, 3);

    // Back to offset 1, then SEEK_COL 0 needs three rotations
    cmd(ROT_LEFT, 0, 0, 0);
    cmd(ROT_LEFT, 0, 0, 0);
    chk("preseek_col_offset", col_offset, 1);
    chk("preseek_lit_out", literals_out, 8'h39);
    cmd_valid = 1'b1; cmd_op = SEEK_COL; cmd_col = 2'd0;
    @(negedge clk);
    cmd_op = ROT_RIGHT;  // held valid while busy; must not be accepted
    busy_cnt = 0; done_cnt = 0; ready_bad = 0; done_at = -1;
    for (int i = 0; i < 8; i++) begin
      if (busy) busy_cnt++;
      if (busy && cmd_ready) ready_bad++;
      if (seek_done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
        cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    $display("seek col=0 busy_cycles=%0d done_pulses=%0d done_at=%0d col_offset=%0d",
             busy_cnt, done_cnt, done_at, col_offset);
    chk("seek_busy_cycles", busy_cnt, 3);
    chk("seek_done_pulses", done_cnt, 1);
    chk("seek_done_at", done_at, 3);
    chk("seek_ready_while_busy", ready_bad, 0);
    chk("seek_col_offset", col_offset, 0);
    chk("seek_lit_out", literals_out, 8'hE4);

    // SEEK_COL to the current offset: immediate done, no busy
    cmd(SEEK_COL, 0, 0, 0);
    chk("seek0_done", seek_done, 1);
    chk("seek0_busy", busy, 0);
    @(negedge clk);
    chk("seek0_done_cleared", seek_done, 0);
    chk("seek0_busy_after", busy, 0);
    chk("seek0_lit_out", literals_out, 8'hE4);

    // Gate-info FIFO
    fifo(1, 0, 2'd1, 32'd101, 32'd201);
    chk("fifo1_count", gi_count, 1);
    chk("fifo1_head_pos", go_pos, 101);
    chk("fifo1_head_type", go_gate_type, 1);
    fifo(1, 0, 2'd2, 32'd102, 32'd202);
    fifo(1, 0, 2'd3, 32'd103, 32'd203);
    fifo(1, 0, 2'd0, 32'd104, 32'd204);
    chk("fifo4_full", gi_full, 1);
    chk("fifo4_count", gi_count, 4);
    fifo(1, 0, 2'd1, 32'd105, 32'd205);
    chk("fifo_drop_count", gi_count, 4);
    chk("fifo_drop_head", go_pos, 101);
    fifo(1, 1, 2'd2, 32'd106, 32'd206);
    chk("fifo_pp_count", gi_count, 4);
    chk("fifo_pp_head_pos", go_pos, 102);
    chk("fifo_pp_head_pos2", go_pos2, 202);
    fifo(0, 1, 0, 0, 0);
    chk("fifo_pop_head", go_pos, 103);
    fifo(0, 1, 0, 0, 0);
    fifo(0, 1, 0, 0, 0);
    chk("fifo_wrap_head", go_pos, 106);
    chk("fifo_wrap_type", go_gate_type, 2);
    fifo(0, 1, 0, 0, 0);
    chk("fifo_empty", gi_empty, 1);
    chk("fifo_empty_head", go_pos, 0);
    fifo(0, 1, 0, 0, 0);
    chk("fifo_underflow_count", gi_count, 0);

    // P register capture and hold
    literals_P = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    phase_P = 1'b1; valid_P = 1'b1;
    @(negedge clk);
    valid_P = 1'b0;
    literals_P = '1; phase_P = 1'b0;
    chk("p_capture_lit", reg_literals_P, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    chk("p_capture_ph", reg_phase_P, 1);
    @(negedge clk);
    chk("p_hold_lit", reg_literals_P, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);

    // CLEAR zeroes col_offset but leaves P alone; then op 7
    cmd(ROT_LEFT, 0, 0, 0);
    cmd(CLEAR, 0, 0, 0);
    chk("clear_col_offset", col_offset, 0);
    chk("clear_p_kept", reg_phase_P, 1);
    cmd(SHIFT_IN, 0, 8'h11, 16'h1111);
    cmd(SHIFT_IN, 0, 8'h22, 16'h2222);
    cmd(SHIFT_IN, 0, 8'h33, 16'h3333);
    cmd(SHIFT_IN, 0, 8'h44, 16'h4444);
    chk("op7_pre_lit", literals_out, 8'h11);
`ifdef REG_ARRAY_WRITEBACK_EN
    wb_literals = 8'hA5; wb_phase = 16'h1234;
    cmd(WRITEBACK, 0, 8'hFF, 16'hFFFF);
    chk("wb_lit_out", literals_out, 8'hA5);
    chk("wb_ph_out", phase_out, 16'h1234);
`else
    cmd(WRITEBACK, 0, 8'hFF, 16'hFFFF);
    chk("op7_nop_lit", literals_out, 8'h11);
    chk("op7_nop_ph", phase_out, 16'h1111);
`endif
    cmd(ROT_DOWN, 0, 0, 0);
    chk("op7_row2_lit", literals_out, 8'h22);
    chk("op7_row2_ph", phase_out, 16'h2222);
    cmd(ROT_DOWN, 0, 0, 0);
    chk("op7_row1_lit", literals_out, 8'h33);

    // Reset in the middle of a seek
    fifo(1, 0, 2'd3, 32'd77, 32'd78);
    cmd(ROT_LEFT, 0, 0, 0);
    cmd_valid = 1'b1; cmd_op = SEEK_COL; cmd_col = 2'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("midseek_busy", busy, 1);
    #2 rst_new = 1'b1;
    #1;
    chk("midseek_rst_busy", busy, 0);
    chk("midseek_rst_col_offset", col_offset, 0);
    chk("midseek_rst_lit_out", literals_out, 0);
    chk("midseek_rst_gi_count", gi_count, 0);
    chk("midseek_rst_p_ph", reg_phase_P, 0);
    @(negedge clk);
    rst_new = 1'b0;
    done_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (seek_done) done_cnt++;
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    $display("post-reset idle window: done_pulses=%0d busy_cycles=%0d", done_cnt, busy_cnt);
    chk("midseek_no_done", done_cnt, 0);
    chk("midseek_no_busy", busy_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
